// File: rtl/id_ex_operand_stage_pkg.sv
// Shared core definitions: datapath widths, ALU opcodes and the ID/EX
// control bundle together with its bubble value.
package id_ex_operand_stage_pkg;

  localparam int DATA_W = 32;
  localparam int RA_W   = 5;
  localparam int CNT_W  = 16;

  // ALU operation codes driven on alu_ctrl.
  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_MULT = 4'b0011,
    ALU_LUI  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_XOR  = 4'b1000,
    ALU_NOR  = 4'b1100
  } alu_op_e;

  // A bubble drives AND of zero operands, so the ALU result is 0.
  localparam logic [3:0] ALU_NOP = ALU_AND;

  // Decoded control bits carried through the ID/EX register.
  typedef struct packed {
    logic valid;
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ex_ctrl_t;

  // Control content of an inserted bubble: invalid, no memory access,
  // no write-back.
  localparam ex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_operand_stage_fwd.sv
// Forwarding selector for one ALU source register. EX/MEM has priority
// over MEM/WB; register $0 is never forwarded.
module fwd_sel #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic [RA_W-1:0]   ra,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              exmem_reg_write,
  input  logic [RA_W-1:0]   exmem_wr,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [RA_W-1:0]   memwb_wr,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] data
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_reg_write && (exmem_wr != '0) && (exmem_wr == ra);
  assign memwb_hit = memwb_reg_write && (memwb_wr != '0) && (memwb_wr == ra);

  // Priority mux: newest producer first, register file last.
  always_comb begin
    // NOTE: every path assigns data, so no latch is inferred.
    data = rf_data;
    if (exmem_hit) begin
      data = exmem_result;
    end else if (memwb_hit) begin
      data = memwb_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold,
// operand forwarding and a saturating bubble counter.
module id_ex_operand_stage #(
  parameter int DATA_W = id_ex_operand_stage_pkg::DATA_W,
  parameter int RA_W   = id_ex_operand_stage_pkg::RA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [RA_W-1:0]   id_rs_i,
  input  logic [RA_W-1:0]   id_rt_i,
  input  logic [RA_W-1:0]   id_wr_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [3:0]        id_alu_ctrl_i,
  input  logic [4:0]        id_shamt_i,
  input  logic              id_alu_src_i,
  input  logic              id_mem_read_i,
  input  logic              id_mem_write_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_to_reg_i,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              exmem_reg_write_i,
  input  logic [RA_W-1:0]   exmem_wr_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [RA_W-1:0]   memwb_wr_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [DATA_W-1:0] src1_o,
  output logic [DATA_W-1:0] src2_o,
  output logic [3:0]        alu_ctrl_o,
  output logic [4:0]        shamt_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic              ex_valid_o,
  output logic [RA_W-1:0]   ex_wr_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_to_reg_o,
  output logic              stall_o,
  output logic [15:0]       bubble_cnt_o
);

  import id_ex_operand_stage_pkg::*;

  typedef struct packed {
    ex_ctrl_t          ctrl;
    logic [3:0]        alu_ctrl;
    logic [4:0]        shamt;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   wr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } id_ex_t;

  id_ex_t            ex_q;
  id_ex_t            id_word;
  id_ex_t            bubble_word;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // Pack the ID-side inputs into the register format.
  always_comb begin
    id_word                 = '0;
    id_word.ctrl.valid      = id_valid_i;
    id_word.ctrl.alu_src    = id_alu_src_i;
    id_word.ctrl.mem_read   = id_mem_read_i;
    id_word.ctrl.mem_write  = id_mem_write_i;
    id_word.ctrl.reg_write  = id_reg_write_i;
    id_word.ctrl.mem_to_reg = id_mem_to_reg_i;
    id_word.alu_ctrl        = id_alu_ctrl_i;
    id_word.shamt           = id_shamt_i;
    id_word.rs              = id_rs_i;
    id_word.rt              = id_rt_i;
    id_word.wr              = id_wr_i;
    id_word.rs_data         = id_rs_data_i;
    id_word.rt_data         = id_rt_data_i;
    id_word.imm             = id_imm_i;
  end

  // Bubble content: no control, NOP opcode, zero data.
  always_comb begin
    bubble_word          = '0;
    bubble_word.ctrl     = BUBBLE_CTRL;
    bubble_word.alu_ctrl = ALU_NOP;
  end

  // Load-use hazard: a valid load in EX writes a register the ID
  // instruction reads.
  assign stall_o = ex_q.ctrl.valid && ex_q.ctrl.mem_read && id_valid_i &&
                   (ex_q.wr != '0) &&
                   ((ex_q.wr == id_rs_i) || (ex_q.wr == id_rt_i));

  // ID/EX register and bubble counter: reset > flush > hold > stall > load.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst_i) begin
      ex_q       <= '0;
      bubble_cnt <= '0;
    end else if (flush_i) begin
      ex_q <= bubble_word;
    end else if (hold_i) begin
      ex_q <= ex_q;
    end else if (stall_o) begin
      ex_q <= bubble_word;
      if (bubble_cnt != '1) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end else begin
      ex_q <= id_word;
    end
  end

  fwd_sel #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs (
    .ra              (ex_q.rs),
    .rf_data         (ex_q.rs_data),
    .exmem_reg_write (exmem_reg_write_i),
    .exmem_wr        (exmem_wr_i),
    .exmem_result    (exmem_result_i),
    .memwb_reg_write (memwb_reg_write_i),
    .memwb_wr        (memwb_wr_i),
    .memwb_data      (memwb_data_i),
    .data            (fwd_rs)
  );

  fwd_sel #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rt (
    .ra              (ex_q.rt),
    .rf_data         (ex_q.rt_data),
    .exmem_reg_write (exmem_reg_write_i),
    .exmem_wr        (exmem_wr_i),
    .exmem_result    (exmem_result_i),
    .memwb_reg_write (memwb_reg_write_i),
    .memwb_wr        (memwb_wr_i),
    .memwb_data      (memwb_data_i),
    .data            (fwd_rt)
  );

  assign src1_o          = fwd_rs;
  assign store_data_o    = fwd_rt;
  assign src2_o          = ex_q.ctrl.alu_src ? ex_q.imm : fwd_rt;
  assign alu_ctrl_o      = ex_q.alu_ctrl;
  assign shamt_o         = ex_q.shamt;
  assign ex_valid_o      = ex_q.ctrl.valid;
  assign ex_wr_o         = ex_q.wr;
  assign ex_mem_read_o   = ex_q.ctrl.mem_read;
  assign ex_mem_write_o  = ex_q.ctrl.mem_write;
  assign ex_reg_write_o  = ex_q.ctrl.reg_write;
  assign ex_mem_to_reg_o = ex_q.ctrl.mem_to_reg;
  assign bubble_cnt_o    = bubble_cnt;

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register and operand-delivery stage of the pipelined MIPS core, directly upstream of the ALU. Captures decoded operands and control from ID each cycle, inserts bubbles on load-use hazards and branch flushes, and forwards EX/MEM and MEM/WB results so that the ALU receives final `src1`, `src2`, `ctrl` and `shamt` values. Also keeps a saturating count of inserted load-use bubbles for performance debug.

## Interface
- `DATA_W`, 32: datapath width.
- `RA_W`, 5: register-address width.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `id_valid_i`  in  1  ID holds a real instruction.
- `id_rs_data_i`, `id_rt_data_i`  in  DATA_W  register-file read data.
- `id_rs_i`, `id_rt_i`, `id_wr_i`  in  RA_W  source and destination register numbers.
- `id_imm_i`  in  DATA_W  sign- or zero-extended immediate.
- `id_alu_ctrl_i`  in  4  ALU operation code; `id_shamt_i`  in  5  shift amount.
- `id_alu_src_i`, `id_mem_read_i`, `id_mem_write_i`, `id_reg_write_i`, `id_mem_to_reg_i`  in  1 each  decoded control.
- `flush_i`  in  1  branch or jump taken: squash the instruction entering EX.
- `hold_i`  in  1  downstream stall: freeze this stage.
- `exmem_reg_write_i`  in  1, `exmem_wr_i`  in  RA_W, `exmem_result_i`  in  DATA_W  EX/MEM forwarding source.
- `memwb_reg_write_i`  in  1, `memwb_wr_i`  in  RA_W, `memwb_data_i`  in  DATA_W  MEM/WB forwarding source.
- `src1_o`, `src2_o`  out  DATA_W  ALU operands.
- `alu_ctrl_o`  out  4, `shamt_o`  out  5  to the ALU.
- `store_data_o`  out  DATA_W  forwarded rt value for stores.
- `ex_valid_o`, `ex_wr_o`, `ex_mem_read_o`, `ex_mem_write_o`, `ex_reg_write_o`, `ex_mem_to_reg_o`  out  registered control passed to EX/MEM.
- `stall_o`  out  1  freeze PC and IF/ID this cycle.
- `bubble_cnt_o`  out  16  saturating count of load-use bubbles.

## Operation
- The ID/EX register holds the valid bit, rs/rt data, register numbers, immediate, ctrl, shamt and the five control bits.
- Load-use hazard (combinational): `stall_o` = `ex_valid & ex_mem_read & id_valid_i & ex_wr != 0 & (ex_wr == id_rs_i | ex_wr == id_rt_i)`.
- Per-edge update, highest priority first:
  - `rst_i`: clear all fields and the counter.
  - `flush_i`: load a bubble (valid=0, all control bits 0, ctrl=0000, data 0).
  - `hold_i`: keep every field unchanged; `stall_o` is still driven and the counter does not change.
  - `stall_o`: load a bubble and increment `bubble_cnt_o`, saturating at 0xFFFF.
  - Otherwise: load the ID inputs.
- A bubble has ctrl=0000, so the ALU result is 0 and nothing is written back.
- Forwarding, separately for rs and rt (combinational, from the registered register numbers):
  - Use EX/MEM if its `reg_write` is set, its `wr` is nonzero and `wr` matches.
  - Otherwise use MEM/WB under the same conditions.
  - Otherwise use the registered register-file data.
  - EX/MEM always wins when both sources match.
- Outputs:
  - `src1_o` = forwarded rs; `store_data_o` = forwarded rt.
  - `src2_o` = `alu_src ? imm : forwarded rt`.
  - `alu_ctrl_o` and `shamt_o` come straight from the register.
- Register $0 is never forwarded.
- All arithmetic stays at DATA_W; there is no width extension in this block.

## Timing
- Reset values: every registered output is 0, `bubble_cnt_o` = 0.
  - `src1_o`, `src2_o` and `store_data_o` are 0 unless a forwarding source matches register 0. That cannot happen, because $0 is never forwarded.
  - `stall_o` = 0.
- Latency: ID inputs appear on the outputs one cycle after the edge that captures them.
- The forwarding path is zero-latency: same-cycle EX/MEM and MEM/WB values go straight to the ALU operands.
- A load-use hazard causes exactly one bubble. In the following cycle the load is in MEM and its result arrives through MEM/WB forwarding, so `stall_o` falls.
- Flush and hazard in the same cycle: the flush bubble is loaded; `stall_o` is still asserted that cycle and the counter does not increment.
- Reset asserted mid-hold or mid-stall: cleared on that edge; the next cycle is a normal load.
- Counter saturation: 0xFFFF stays at 0xFFFF.

## Structure
- Shared core package holds:
  - the ALU opcode constants (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLL 0101, LUI 0100, MULT 0011, etc.);
  - `DATA_W` and `RA_W`;
  - the bubble control constant.
- One sub-module, `fwd_sel`, instantiated twice (rs and rt). It takes the register number, the register-file data and both forwarding sources, and returns the selected value.

## Test plan
- Forwarding priority:
  - EX holds `add $3`; `exmem_wr`=3 with result 0x11 and `memwb_wr`=3 with data 0x22. Expect `src1_o`=0x11.
  - Drop the EX/MEM `reg_write`. Expect `src1_o`=0x22.
- Load-use:
  - EX holds `lw $5` (mem_read=1, wr=5); ID has rs=5, valid. Expect `stall_o`=1.
  - Next cycle: `ex_valid_o`=0, `alu_ctrl_o`=0000, `bubble_cnt_o`=1, `stall_o`=0.
- Register $0: EX/MEM writes $0 with 0xDEAD and the EX instruction reads rs=0 with register-file data 0. Expect `src1_o`=0.
- Immediate path: `alu_src`=1, imm=0x0000_FFFC, rt forwarded as 0x5. Expect `src2_o`=0xFFFC and `store_data_o`=0x5.
- Hold, flush and reset:
  - Hold for 3 cycles with changing ID inputs. The outputs stay constant.
  - Flush together with a hazard. Expect a bubble loaded and the counter unchanged.
  - `rst_i` during hold. All outputs are 0 on the next cycle.
- Saturation: preload by forcing 65535 hazards. A further hazard keeps `bubble_cnt_o`=0xFFFF.
